// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision FP datapath blocks.
package fp_pkg;

    localparam int XLEN  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    // Quotient width: implicit one, the stored fraction, and one extra bit.
    // The extra bit lets a quotient below 1.0 still fill the fraction.
    localparam int QUOT_W = MAN_W + 2;

    localparam logic [XLEN-1:0]  QNAN    = 32'h7FC00000;
    localparam logic [XLEN-1:0]  POS_INF = 32'h7F800000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_NORM,
        S_DONE
    } div_state_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_norm;
    } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand decode into zero/inf/NaN/normal classes.
// Subnormals are treated as zero.
// The sign is not needed for classification, so only the magnitude is passed in.
module fp_classify
    import fp_pkg::*;
(
    input  logic [XLEN-2:0] mag,
    output fp_class_t       cls
);

    logic [EXP_W-1:0] exp_f;
    logic             man_nz;

    // Classify purely on exponent and nonzero fraction.
    always_comb begin
        exp_f       = mag[XLEN-2 -: EXP_W];
        man_nz      = |mag[MAN_W-1:0];
        cls.is_zero = (exp_f == '0);
        cls.is_inf  = (exp_f == EXP_MAX) && !man_nz;
        cls.is_nan  = (exp_f == EXP_MAX) && man_nz;
        cls.is_norm = (exp_f != '0) && (exp_f != EXP_MAX);
    end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative single-precision divider using restoring division.
// It produces one quotient bit per clock.
// Valid/ready handshakes are used on the input side and the output side.
module fp_div_seq
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            overflow,
    output logic            underflow,
    output logic            div_by_zero,
    output logic            invalid
);

    localparam int EXT_W = EXP_W + 2;
    localparam logic signed [EXT_W-1:0] BIAS_EXT = EXT_W'(BIAS);
    localparam logic signed [EXT_W-1:0] EXP_LIMIT = {2'b00, EXP_MAX};

    div_state_t state, next_state;
    fp_class_t  cls_a, cls_b;

    logic                    accept;
    logic                    sign_x;
    logic                    special;
    logic                    special_invalid;
    logic                    special_dbz;
    logic [XLEN-1:0]         special_result;
    logic signed [EXT_W-1:0] exp_in;

    logic                    sign_q;
    logic signed [EXT_W-1:0] exp_q;
    logic [MAN_W+2:0]        rem;
    logic [MAN_W:0]          divisor;
    logic [QUOT_W-1:0]       quot;
    logic [4:0]              cnt;

    logic [MAN_W+2:0]        diff;
    logic                    rem_ge;
    logic signed [EXT_W-1:0] norm_exp;
    logic [MAN_W-1:0]        norm_man;

    fp_classify u_cls_a (.mag(in1[XLEN-2:0]), .cls(cls_a));
    fp_classify u_cls_b (.mag(in2[XLEN-2:0]), .cls(cls_b));

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;

    // Resolve special operands by precedence.
    // The first matching case decides the result and the flags.
    always_comb begin
        sign_x          = in1[XLEN-1] ^ in2[XLEN-1];
        special         = 1'b1;
        special_result  = QNAN;
        special_invalid = 1'b1;
        special_dbz     = 1'b0;
        exp_in = $signed({2'b00, in1[XLEN-2 -: EXP_W]})
               - $signed({2'b00, in2[XLEN-2 -: EXP_W]}) + BIAS_EXT;
        if (cls_a.is_nan || cls_b.is_nan) begin
            special = 1'b1;
        end else if ((cls_a.is_zero && cls_b.is_zero) || (cls_a.is_inf && cls_b.is_inf)) begin
            special = 1'b1;
        end else if (cls_b.is_zero && !cls_a.is_inf) begin
            special_result  = POS_INF | {sign_x, {(XLEN-1){1'b0}}};
            special_invalid = 1'b0;
            special_dbz     = 1'b1;
        end else if (cls_a.is_inf) begin
            special_result  = POS_INF | {sign_x, {(XLEN-1){1'b0}}};
            special_invalid = 1'b0;
        end else if (cls_a.is_zero || cls_b.is_inf) begin
            special_result  = '0;
            special_invalid = 1'b0;
        end else begin
            special         = !(cls_a.is_norm && cls_b.is_norm);
            special_invalid = 1'b0;
        end
    end

    // Run one restoring step and prepare normalisation of the quotient.
    always_comb begin
        diff   = rem - {2'b00, divisor};
        rem_ge = (rem >= {2'b00, divisor});
        if (quot[QUOT_W-1]) begin
            norm_man = quot[MAN_W:1];
            norm_exp = exp_q;
        end else begin
            norm_man = quot[MAN_W-1:0];
            norm_exp = exp_q - EXT_W'(1);
        end
    end

    // State register.
    // An asynchronous reset aborts any operation in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Compute the next state.
    // Specials skip the iteration entirely.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept) next_state = special ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (cnt == 5'(QUOT_W - 1)) next_state = S_NORM;
            S_NORM:   next_state = S_DONE;
            S_DONE:   if (out_ready) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Datapath: latch the operands, iterate the quotient, and pack the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result      <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            rem         <= '0;
            divisor     <= '0;
            quot        <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        overflow    <= 1'b0;
                        underflow   <= 1'b0;
                        div_by_zero <= special_dbz;
                        invalid     <= special_invalid;
                        sign_q      <= sign_x;
                        exp_q       <= exp_in;
                        rem         <= {2'b01, in1[MAN_W-1:0]};
                        divisor     <= {1'b1, in2[MAN_W-1:0]};
                        quot        <= '0;
                        cnt         <= '0;
                        if (special) result <= special_result;
                    end
                end
                S_DIVIDE: begin
                    quot <= {quot[QUOT_W-2:0], rem_ge};
                    rem  <= rem_ge ? {diff[MAN_W+1:0], 1'b0} : {rem[MAN_W+1:0], 1'b0};
                    cnt  <= cnt + 5'd1;
                end
                S_NORM: begin
                    if (norm_exp >= EXP_LIMIT) begin
                        result   <= POS_INF | {sign_q, {(XLEN-1){1'b0}}};
                        overflow <= 1'b1;
                    end else if (norm_exp[EXT_W-1] || norm_exp == '0) begin
                        result    <= '0;
                        underflow <= 1'b1;
                    end else begin
                        result <= {sign_q, norm_exp[EXP_W-1:0], norm_man};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard-driven bench for the sequential FP divider.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;
    logic        invalid;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        int          latency;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   check_count = 0;
    int   pass_count  = 0;

    always #5 clk = ~clk;

    fp_div_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .underflow(underflow),
        .div_by_zero(div_by_zero), .invalid(invalid)
    );

    // Drive one operation and wait a bounded time for its output.
    // Then complete the output handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [3:0] flg,
                          output int lat, output bit timed_out);
        @(negedge clk);
        in1 = a; in2 = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        timed_out = !out_valid;
        res = result;
        flg = {overflow, underflow, div_by_zero, invalid};
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        check_count++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        else pass_count++;
        check_count++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        else pass_count++;
        check_count++;
        if (result !== 32'h0) $display("[TB] FAIL reset_result: got %h expected 00000000", result);
        else pass_count++;
        check_count++;
        if ({overflow, underflow, div_by_zero, invalid} !== 4'b0)
            $display("[TB] FAIL reset_flags: got %b expected 0000", {overflow, underflow, div_by_zero, invalid});
        else pass_count++;
        rst_n = 1'b1;
    endtask

    task automatic test_normal;
        logic [31:0] a   [4] = '{32'h40C00000, 32'hC3480000, 32'h3F800000, 32'h40000000};
        logic [31:0] b   [4] = '{32'h40000000, 32'h41200000, 32'h40400000, 32'h40800000};
        logic [31:0] exr [4] = '{32'h40400000, 32'hC1A00000, 32'h3EAAAAAA, 32'h3F000000};
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        bit          to;
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{res: exr[i], flags: 4'b0000, latency: 27, name: $sformatf("normal%0d", i)});
            run_op(a[i], b[i], res, flg, lat, to);
            e = sb.pop_front();
            check_count++;
            if (to) $display("[TB] FAIL %s_timeout: no out_valid after %0d cycles", e.name, lat);
            else pass_count++;
            check_count++;
            if (res !== e.res) $display("[TB] FAIL %s_result: got %h expected %h", e.name, res, e.res);
            else pass_count++;
            check_count++;
            if (flg !== e.flags) $display("[TB] FAIL %s_flags: got %b expected %b", e.name, flg, e.flags);
            else pass_count++;
            check_count++;
            if (lat != e.latency) $display("[TB] FAIL %s_latency: got %0d expected %0d", e.name, lat, e.latency);
            else pass_count++;
        end
    endtask

    task automatic test_special;
        logic [31:0] a   [11] = '{32'h3F800000, 32'h00000000, 32'h7FC00000, 32'h7F800000,
                                  32'h3F800000, 32'h3F800000, 32'h7F800000, 32'hFF800000,
                                  32'h80000000, 32'h40A00000, 32'h00000001};
        logic [31:0] b   [11] = '{32'h00000000, 32'h00000000, 32'h3F800000, 32'h7F800000,
                                  32'h7FC00001, 32'h80000000, 32'h00000000, 32'h40000000,
                                  32'h40A00000, 32'hFF800000, 32'h3F800000};
        logic [31:0] exr [11] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                                  32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'hFF800000,
                                  32'h00000000, 32'h00000000, 32'h00000000};
        logic [3:0]  exf [11] = '{4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                                  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        bit          to;
        exp_t        e;
        for (int i = 0; i < 11; i++) begin
            sb.push_back('{res: exr[i], flags: exf[i], latency: 1, name: $sformatf("special%0d", i)});
            run_op(a[i], b[i], res, flg, lat, to);
            e = sb.pop_front();
            check_count++;
            if (to) $display("[TB] FAIL %s_timeout: no out_valid after %0d cycles", e.name, lat);
            else pass_count++;
            check_count++;
            if (res !== e.res) $display("[TB] FAIL %s_result: got %h expected %h", e.name, res, e.res);
            else pass_count++;
            check_count++;
            if (flg !== e.flags) $display("[TB] FAIL %s_flags: got %b expected %b", e.name, flg, e.flags);
            else pass_count++;
            check_count++;
            if (lat != e.latency) $display("[TB] FAIL %s_latency: got %0d expected %0d", e.name, lat, e.latency);
            else pass_count++;
        end
    endtask

    task automatic test_range;
        logic [31:0] a   [6] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00800000, 32'h00800000,
                                 32'hFF7FFFFF, 32'h80800000};
        logic [31:0] b   [6] = '{32'h3F000000, 32'h3F800000, 32'h40000000, 32'h3F800000,
                                 32'h3F000000, 32'h40000000};
        logic [31:0] exr [6] = '{32'h7F800000, 32'h7F7FFFFF, 32'h00000000, 32'h00800000,
                                 32'hFF800000, 32'h00000000};
        logic [3:0]  exf [6] = '{4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0100};
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        bit          to;
        exp_t        e;
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{res: exr[i], flags: exf[i], latency: 27, name: $sformatf("range%0d", i)});
            run_op(a[i], b[i], res, flg, lat, to);
            e = sb.pop_front();
            check_count++;
            if (to) $display("[TB] FAIL %s_timeout: no out_valid after %0d cycles", e.name, lat);
            else pass_count++;
            check_count++;
            if (res !== e.res) $display("[TB] FAIL %s_result: got %h expected %h", e.name, res, e.res);
            else pass_count++;
            check_count++;
            if (flg !== e.flags) $display("[TB] FAIL %s_flags: got %b expected %b", e.name, flg, e.flags);
            else pass_count++;
            check_count++;
            if (lat != e.latency) $display("[TB] FAIL %s_latency: got %0d expected %0d", e.name, lat, e.latency);
            else pass_count++;
        end
    endtask

    task automatic test_backpressure;
        int   lat;
        exp_t e;
        @(negedge clk);
        sb.push_back('{res: 32'h40400000, flags: 4'b0000, latency: 27, name: "bp_first"});
        in1 = 32'h40C00000; in2 = 32'h40000000; in_valid = 1'b1;
        @(negedge clk);
        sb.push_back('{res: 32'h3EAAAAAA, flags: 4'b0000, latency: 27, name: "bp_second"});
        in1 = 32'h3F800000; in2 = 32'h40400000;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check_count++;
        if (lat != e.latency) $display("[TB] FAIL %s_latency: got %0d expected %0d", e.name, lat, e.latency);
        else pass_count++;
        for (int i = 0; i < 5; i++) begin
            check_count++;
            if (out_valid !== 1'b1 || result !== e.res)
                $display("[TB] FAIL bp_hold%0d_result: got valid=%b %h expected valid=1 %h", i, out_valid, result, e.res);
            else pass_count++;
            check_count++;
            if ({overflow, underflow, div_by_zero, invalid} !== e.flags || in_ready !== 1'b0)
                $display("[TB] FAIL bp_hold%0d_flags: got %b ready=%b expected %b ready=0",
                         i, {overflow, underflow, div_by_zero, invalid}, in_ready, e.flags);
            else pass_count++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_count++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("[TB] FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        else pass_count++;
        @(negedge clk);
        in_valid = 1'b0;
        check_count++;
        if (in_ready !== 1'b0) $display("[TB] FAIL bp_pending_accept: got in_ready=%b expected 0", in_ready);
        else pass_count++;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check_count++;
        if (result !== e.res) $display("[TB] FAIL %s_result: got %h expected %h", e.name, result, e.res);
        else pass_count++;
        check_count++;
        if (lat != e.latency) $display("[TB] FAIL %s_latency: got %0d expected %0d", e.name, lat, e.latency);
        else pass_count++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        bit          to;
        exp_t        e;
        @(negedge clk);
        in1 = 32'h40C00000; in2 = 32'h40000000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check_count++;
        if (in_ready !== 1'b0) $display("[TB] FAIL abort_busy: got in_ready=%b expected 0", in_ready);
        else pass_count++;
        rst_n = 1'b0;
        #1;
        check_count++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("[TB] FAIL abort_state: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        else pass_count++;
        check_count++;
        if (result !== 32'h0) $display("[TB] FAIL abort_result: got %h expected 00000000", result);
        else pass_count++;
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{res: 32'h40400000, flags: 4'b0000, latency: 27, name: "after_abort"});
        run_op(32'h40C00000, 32'h40000000, res, flg, lat, to);
        e = sb.pop_front();
        check_count++;
        if (to || res !== e.res) $display("[TB] FAIL %s_result: got %h expected %h", e.name, res, e.res);
        else pass_count++;
        check_count++;
        if (flg !== e.flags || lat != e.latency)
            $display("[TB] FAIL %s_flags_latency: got %b/%0d expected %b/%0d", e.name, flg, lat, e.flags, e.latency);
        else pass_count++;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in1 = '0; in2 = '0;
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_backpressure();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
